game_control_fsm: RTL and testbench
===================================

Name: game_control_fsm

Overview:
Control unit for the moving-dot maze game. It drives the select/enable inputs of the game datapath (position, move, timer and colour stages) and consumes its flags (timer_done, obs_black, did_win). It sequences the game loop: draw dot, wait one frame tick, sample the player direction, check the target pixel, erase, step, test for win. It sits directly upstream of the datapath; the datapath's xpos/ypos/color_draw outputs feed the VGA adapter.

Parameters:
FRAMES_PER_STEP, 1, number of timer_done expiries between move attempts (1..15).
FCNT_W, 4, width of the frame counter.

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
start  input  1  level, synchronous; a rising edge starts or restarts the game
dir_req  input  4  {up,down,left,right}, active-high level from the key debouncer
timer_done  input  1  datapath flag: frame timer reached 2^19
obs_black  input  1  datapath flag: pixel at target of s_move is black (free)
did_win  input  1  datapath flag: current position equals goal
plot  output  1  one-cycle write strobe to the datapath VGA stage
s_color  output  1  1=RED dot, 0=BLACK erase
en_timer  output  1  timer enable
s_timer  output  1  1=count, 0=clear
en_move  output  1  load move register
s_move  output  3  0=none, 1=up, 2=down, 3=left, 4=right
en_xpos  output  1  x position enable
s_xpos  output  2  0=init, 1=+1, 2=-1
en_ypos  output  1  y position enable
s_ypos  output  2  0=init, 1=+1, 2=-1
game_won  output  1  high while in WIN
state_dbg  output  4  current state encoding, for LEDs

Behaviour:
- Reset (resetn=0, async): state=IDLE; pending=0; fcnt=0; start_q=0. All outputs are 0 and state_dbg=0.
- Moore outputs: combinational decode of the state register only; s_move is combinational from the pending register in SAMPLE.
- start_q registers start each cycle. start_edge = start & ~start_q.
- pending[3:0]: in WAIT it ORs in dir_req every cycle (sticky). It clears on the SAMPLE exit cycle, on reset, and in INIT.
- Direction priority when several bits are set: up > down > left > right.
- States, with encodings and transitions:
  - IDLE(0) -> INIT on start_edge.
  - INIT(1): en_xpos=en_ypos=1, s_xpos=s_ypos=0 -> DRAW.
  - DRAW(2): plot=1, s_color=1 -> TCLR.
  - TCLR(3): en_timer=1, s_timer=0 -> WAIT.
  - WAIT(4): en_timer=1, s_timer=1. On timer_done: fcnt+1. If fcnt+1==FRAMES_PER_STEP then fcnt=0 -> SAMPLE, else -> TCLR.
  - SAMPLE(5): en_move=1, s_move=priority(pending); pending cleared. If pending==0 -> TCLR (s_move=0 still loaded), else -> CHECK.
  - CHECK(6): datapath target flag valid this cycle. obs_black=1 -> ERASE; obs_black=0 -> TCLR (move discarded, dot stays drawn).
  - ERASE(7): plot=1, s_color=0 -> STEP.
  - STEP(8): up: en_ypos=1, s_ypos=2; down: en_ypos=1, s_ypos=1; left: en_xpos=1, s_xpos=2; right: en_xpos=1, s_xpos=1. -> TWIN.
  - TWIN(9): did_win=1 -> WIN; else -> DRAW.
  - WIN(10): game_won=1, no plot -> INIT on start_edge.
- start_edge in any state other than IDLE or WIN is ignored.
- plot is never high for two consecutive cycles. DRAW follows ERASE by exactly 3 cycles (ERASE, STEP, TWIN).
- Move latency: timer_done sampled in WAIT -> plot(erase) 3 cycles later -> plot(draw) 6 cycles later.
- Reset mid-operation, including with plot high, forces IDLE immediately; no partial erase is completed.
- fcnt is reset to 0 only by reset or INIT. It wraps modulo FRAMES_PER_STEP via the compare above, never modulo 2^FCNT_W.

Decomposition:
- Shared package game_pkg holds:
  - state enum (11 states, 4-bit);
  - S_MOVE_* codes (NONE=0, UP=1, DOWN=2, LEFT=3, RIGHT=4);
  - S_POS_INIT/INC/DEC (0/1/2);
  - colour constants BLACK=3'b000, RED=3'b100, GREEN=3'b010.
- One sub-module: dir_latch (sticky pending register plus priority encoder to s_move). The FSM stays in the top.

Test Plan:
- Reset/start: resetn low 3 cycles, start 0->1 -> state_dbg 0 -> 1 -> 2 -> 3. plot=1, s_color=1 in exactly one cycle. All outputs 0 during reset.
- Single move: FRAMES_PER_STEP=1; pulse dir_req=4'b0001 (right) for 1 cycle in WAIT; stub timer_done=1, obs_black=1, did_win=0 -> SAMPLE s_move=4. ERASE plot with s_color=0. STEP en_xpos=1, s_xpos=1. DRAW plot with s_color=1 three cycles after ERASE.
- Priority and blocking: dir_req=4'b1011 then timer_done, obs_black=0 -> s_move=1 (up). No plot in the following 3 cycles; state returns to TCLR; pending is 0.
- Frame divide: FRAMES_PER_STEP=3 with pending set -> SAMPLE only on the 3rd timer_done. TCLR is entered after the 1st and 2nd.
- Win and restart: obs_black=1, did_win=1 after STEP -> game_won=1 and held 100 cycles with no plot. start edge -> INIT (state_dbg 1), game_won=0.
- Async reset mid-ERASE: drop resetn during the ERASE cycle (not on a clock edge) -> plot falls immediately, state_dbg=0, pending=0. start edge afterward reruns INIT.

Source files
------------

// File: rtl/game_control_fsm_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the moving-dot maze game control unit.
//   state_t       : the 11 FSM states. The encoding is exported on state_dbg.
//   S_MOVE_*      : move-register select codes driven on s_move.
//   S_POS_*       : position-stage select codes driven on s_xpos / s_ypos.
//   COLOR_*       : 3-bit VGA colour values used by the datapath colour stage.
//   dir_to_move() : priority encoder for the direction request bits.
// ---------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_INIT   = 4'd1,
        ST_DRAW   = 4'd2,
        ST_TCLR   = 4'd3,
        ST_WAIT   = 4'd4,
        ST_SAMPLE = 4'd5,
        ST_CHECK  = 4'd6,
        ST_ERASE  = 4'd7,
        ST_STEP   = 4'd8,
        ST_TWIN   = 4'd9,
        ST_WIN    = 4'd10
    } state_t;

    localparam logic [2:0] S_MOVE_NONE  = 3'd0;
    localparam logic [2:0] S_MOVE_UP    = 3'd1;
    localparam logic [2:0] S_MOVE_DOWN  = 3'd2;
    localparam logic [2:0] S_MOVE_LEFT  = 3'd3;
    localparam logic [2:0] S_MOVE_RIGHT = 3'd4;

    localparam logic [1:0] S_POS_INIT = 2'd0;
    localparam logic [1:0] S_POS_INC  = 2'd1;
    localparam logic [1:0] S_POS_DEC  = 2'd2;

    localparam logic [2:0] COLOR_BLACK = 3'b000;
    localparam logic [2:0] COLOR_RED   = 3'b100;
    localparam logic [2:0] COLOR_GREEN = 3'b010;

    // Direction bits are {up, down, left, right}; up wins, right loses.
    function automatic logic [2:0] dir_to_move(input logic [3:0] dir);
        logic [2:0] code;
        if (dir[3])      code = S_MOVE_UP;
        else if (dir[2]) code = S_MOVE_DOWN;
        else if (dir[1]) code = S_MOVE_LEFT;
        else if (dir[0]) code = S_MOVE_RIGHT;
        else             code = S_MOVE_NONE;
        return code;
    endfunction

endpackage

// File: rtl/game_control_fsm_if.sv
// ---------------------------------------------------------------------------
// game_control_fsm_if
// Control/flag bundle between the game control FSM and the game datapath.
//   Control (FSM -> datapath): plot, s_color, en_timer, s_timer, en_move,
//                              s_move, en_xpos, s_xpos, en_ypos, s_ypos
//   Flags   (datapath -> FSM): timer_done, obs_black, did_win
//   master : FSM side.  slave : datapath side.
// ---------------------------------------------------------------------------
interface game_control_fsm_if;

    logic       plot;
    logic       s_color;
    logic       en_timer;
    logic       s_timer;
    logic       en_move;
    logic [2:0] s_move;
    logic       en_xpos;
    logic [1:0] s_xpos;
    logic       en_ypos;
    logic [1:0] s_ypos;
    logic       timer_done;
    logic       obs_black;
    logic       did_win;

    modport master (
        output plot, s_color, en_timer, s_timer, en_move, s_move,
               en_xpos, s_xpos, en_ypos, s_ypos,
        input  timer_done, obs_black, did_win
    );

    modport slave (
        input  plot, s_color, en_timer, s_timer, en_move, s_move,
               en_xpos, s_xpos, en_ypos, s_ypos,
        output timer_done, obs_black, did_win
    );

endinterface

// File: rtl/game_control_fsm_dir_latch.sv
// ---------------------------------------------------------------------------
// dir_latch
// Sticky record of the player's direction requests plus a priority encoder.
//   clk, resetn  : clock, asynchronous active-low reset
//   accumulate   : OR dir_req into the pending register this cycle
//   clear        : empty the pending register (takes priority over accumulate)
//   dir_req[3:0] : {up, down, left, right} requests
//   pending_any  : at least one direction is pending
//   move_code    : S_MOVE_* code of the highest-priority pending direction
// ---------------------------------------------------------------------------
module dir_latch
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       accumulate,
    input  logic       clear,
    input  logic [3:0] dir_req,
    output logic       pending_any,
    output logic [2:0] move_code
);

    logic [3:0] pending_q;
    logic [3:0] pending_d;

    always_comb begin
        pending_d = pending_q;
        if (clear) begin
            pending_d = 4'b0000;
        end else if (accumulate) begin
            pending_d = pending_q | dir_req;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending_q <= 4'b0000;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_any = |pending_q;
    assign move_code   = dir_to_move(pending_q);

endmodule

// File: rtl/game_control_fsm.sv
// ---------------------------------------------------------------------------
// game_control_fsm
// Control unit for the moving-dot maze game. Sequences draw, frame wait,
// direction sample, obstacle check, erase, step and win test, driving the
// datapath select/enable lines.
//   clk, resetn     : clock, asynchronous active-low reset
//   start           : level; a rising edge starts (IDLE) or restarts (WIN)
//   dir_req[3:0]    : {up, down, left, right} from the key debouncer
//   dp (master)     : datapath controls out, timer_done/obs_black/did_win in
//   game_won        : high while in WIN
//   state_dbg[3:0]  : current state encoding
// Parameters:
//   FRAMES_PER_STEP : timer expiries between move attempts (1..15)
//   FCNT_W          : frame counter width
// ---------------------------------------------------------------------------
module game_control_fsm
    import game_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 1,
    parameter int FCNT_W          = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [3:0]          dir_req,
    game_control_fsm_if.master  dp,
    output logic                game_won,
    output logic [3:0]          state_dbg
);

    localparam logic [FCNT_W-1:0] FPS_C = FCNT_W'(FRAMES_PER_STEP);
    localparam logic [FCNT_W-1:0] ONE_C = FCNT_W'(1);

    state_t            state_q,  state_d;
    logic [FCNT_W-1:0] fcnt_q,   fcnt_d;
    logic              start_q,  start_d;
    logic [2:0]        move_q,   move_d;

    logic              start_edge;
    logic [FCNT_W-1:0] fcnt_inc;
    logic              dir_accumulate;
    logic              dir_clear;
    logic              pending_any;
    logic [2:0]        move_code;

    assign start_d    = start;
    assign start_edge = start & ~start_q;
    assign fcnt_inc   = fcnt_q + ONE_C;

    dir_latch u_dir_latch (
        .clk         (clk),
        .resetn      (resetn),
        .accumulate  (dir_accumulate),
        .clear       (dir_clear),
        .dir_req     (dir_req),
        .pending_any (pending_any),
        .move_code   (move_code)
    );

    // Next state plus Moore output decode. move_q keeps the sampled direction
    // for STEP, because the pending register is already empty by then. The
    // frame counter wraps on the FRAMES_PER_STEP compare, not on its width.
    always_comb begin
        state_d        = state_q;
        fcnt_d         = fcnt_q;
        move_d         = move_q;
        dir_accumulate = 1'b0;
        dir_clear      = 1'b0;
        dp.plot        = 1'b0;
        dp.s_color     = 1'b0;
        dp.en_timer    = 1'b0;
        dp.s_timer     = 1'b0;
        dp.en_move     = 1'b0;
        dp.s_move      = S_MOVE_NONE;
        dp.en_xpos     = 1'b0;
        dp.s_xpos      = S_POS_INIT;
        dp.en_ypos     = 1'b0;
        dp.s_ypos      = S_POS_INIT;
        game_won       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_edge) state_d = ST_INIT;
            end
            ST_INIT: begin
                dp.en_xpos = 1'b1;
                dp.en_ypos = 1'b1;
                dir_clear  = 1'b1;
                fcnt_d     = '0;
                move_d     = S_MOVE_NONE;
                state_d    = ST_DRAW;
            end
            ST_DRAW: begin
                dp.plot    = 1'b1;
                dp.s_color = 1'b1;
                state_d    = ST_TCLR;
            end
            ST_TCLR: begin
                dp.en_timer = 1'b1;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                dp.en_timer    = 1'b1;
                dp.s_timer     = 1'b1;
                dir_accumulate = 1'b1;
                if (dp.timer_done) begin
                    if (fcnt_inc == FPS_C) begin
                        fcnt_d  = '0;
                        state_d = ST_SAMPLE;
                    end else begin
                        fcnt_d  = fcnt_inc;
                        state_d = ST_TCLR;
                    end
                end
            end
            ST_SAMPLE: begin
                dp.en_move = 1'b1;
                dp.s_move  = move_code;
                move_d     = move_code;
                dir_clear  = 1'b1;
                state_d    = pending_any ? ST_CHECK : ST_TCLR;
            end
            ST_CHECK: begin
                state_d = dp.obs_black ? ST_ERASE : ST_TCLR;
            end
            ST_ERASE: begin
                dp.plot = 1'b1;
                state_d = ST_STEP;
            end
            ST_STEP: begin
                case (move_q)
                    S_MOVE_UP: begin
                        dp.en_ypos = 1'b1;
                        dp.s_ypos  = S_POS_DEC;
                    end
                    S_MOVE_DOWN: begin
                        dp.en_ypos = 1'b1;
                        dp.s_ypos  = S_POS_INC;
                    end
                    S_MOVE_LEFT: begin
                        dp.en_xpos = 1'b1;
                        dp.s_xpos  = S_POS_DEC;
                    end
                    S_MOVE_RIGHT: begin
                        dp.en_xpos = 1'b1;
                        dp.s_xpos  = S_POS_INC;
                    end
                    default: ;
                endcase
                state_d = ST_TWIN;
            end
            ST_TWIN: begin
                state_d = dp.did_win ? ST_WIN : ST_DRAW;
            end
            ST_WIN: begin
                game_won = 1'b1;
                if (start_edge) state_d = ST_INIT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and bookkeeping registers; reset lands in IDLE at once, so an
    // erase in flight is simply abandoned.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            fcnt_q  <= '0;
            start_q <= 1'b0;
            move_q  <= S_MOVE_NONE;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            start_q <= start_d;
            move_q  <= move_d;
        end
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_game_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_game_control_fsm
// Directed bench for game_control_fsm. Expected plot strobes are queued as
// stimulus is applied and a monitor pops and compares them on every plot.
// Instance A uses FRAMES_PER_STEP=1, instance B uses FRAMES_PER_STEP=3.
// ---------------------------------------------------------------------------
module tb_game_control_fsm;

    logic       clk;
    logic       resetn, start;
    logic [3:0] dir_req;
    logic       game_won;
    logic [3:0] state_dbg;
    logic       b_resetn, b_start;
    logic [3:0] b_dir;
    logic       b_won;
    logic [3:0] b_state;

    game_control_fsm_if ifa ();
    game_control_fsm_if ifb ();

    game_control_fsm #(.FRAMES_PER_STEP(1), .FCNT_W(4)) dut_a (
        .clk(clk), .resetn(resetn), .start(start), .dir_req(dir_req),
        .dp(ifa.master), .game_won(game_won), .state_dbg(state_dbg)
    );

    game_control_fsm #(.FRAMES_PER_STEP(3), .FCNT_W(4)) dut_b (
        .clk(clk), .resetn(b_resetn), .start(b_start), .dir_req(b_dir),
        .dp(ifb.master), .game_won(b_won), .state_dbg(b_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int st;
        int color;
        int gap;
    } plot_exp_t;

    plot_exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic checkOutput(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pushPlot(input int st, input int color, input int gap);
        plot_exp_t e;
        e.st = st; e.color = color; e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pops one expectation per plot strobe; gap is cycles since the last plot.
    task automatic monitorPlots();
        int        cyc = 0;
        int        last = -100;
        logic      prev = 1'b0;
        plot_exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (ifa.plot) begin
                checkOutput("plot_not_consecutive", int'(prev), 0);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_plot: got plot in state %0d, expected no plot",
                             state_dbg);
                end else begin
                    e = sb.pop_front();
                    checkOutput("plot_state", int'(state_dbg), e.st);
                    checkOutput("plot_color", int'(ifa.s_color), e.color);
                    if (e.gap != 0) checkOutput("plot_gap", cyc - last, e.gap);
                end
                last = cyc;
            end
            prev = ifa.plot;
        end
    endtask

    function automatic int allOutA();
        return int'({ifa.plot, ifa.s_color, ifa.en_timer, ifa.s_timer, ifa.en_move,
                     ifa.s_move, ifa.en_xpos, ifa.s_xpos, ifa.en_ypos, ifa.s_ypos,
                     game_won, state_dbg});
    endfunction

    function automatic int stepPosA();
        return int'({ifa.en_xpos, ifa.s_xpos, ifa.en_ypos, ifa.s_ypos});
    endfunction

    // One move attempt on instance A starting from WAIT with obs_black=1.
    task automatic applyStimulus(input logic [3:0] dir, input int exp_move,
                                 input int exp_pos, input logic win);
        dir_req = dir;
        tick();
        dir_req = 4'b0000;
        ifa.timer_done = 1'b1;
        ifa.obs_black  = 1'b1;
        ifa.did_win    = win;
        pushPlot(7, 0, 0);
        if (!win) pushPlot(2, 1, 3);
        tick();
        checkOutput("mv_sample_state", int'(state_dbg), 5);
        checkOutput("mv_s_move", int'(ifa.s_move), exp_move);
        checkOutput("mv_en_move", int'(ifa.en_move), 1);
        ifa.timer_done = 1'b0;
        tick();
        checkOutput("mv_check_state", int'(state_dbg), 6);
        tick();
        checkOutput("mv_erase_state", int'(state_dbg), 7);
        tick();
        checkOutput("mv_step_state", int'(state_dbg), 8);
        checkOutput("mv_step_pos", stepPosA(), exp_pos);
        tick();
        checkOutput("mv_twin_state", int'(state_dbg), 9);
        tick();
        if (win) begin
            checkOutput("mv_win_state", int'(state_dbg), 10);
            checkOutput("mv_game_won", int'(game_won), 1);
        end else begin
            checkOutput("mv_draw_state", int'(state_dbg), 2);
            tick();
            tick();
            checkOutput("mv_wait_state", int'(state_dbg), 4);
        end
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; dir_req = 4'b0000;
        b_resetn = 1'b0; b_start = 1'b0; b_dir = 4'b0000;
        ifa.timer_done = 1'b0; ifa.obs_black = 1'b0; ifa.did_win = 1'b0;
        ifb.timer_done = 1'b0; ifb.obs_black = 1'b0; ifb.did_win = 1'b0;
        fork
            monitorPlots();
        join_none

        // Reset held three cycles: every output low.
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("reset_outputs", allOutA(), 0);
        end
        resetn = 1'b1;
        b_resetn = 1'b1;
        tick();
        checkOutput("idle_state", int'(state_dbg), 0);

        // Start: IDLE -> INIT -> DRAW -> TCLR -> WAIT.
        pushPlot(2, 1, 0);
        start = 1'b1;
        tick();
        checkOutput("init_state", int'(state_dbg), 1);
        checkOutput("init_pos", stepPosA(), 6'b1_00_1_00);
        tick();
        checkOutput("draw_state", int'(state_dbg), 2);
        tick();
        checkOutput("tclr_state", int'(state_dbg), 3);
        checkOutput("tclr_timer", int'({ifa.en_timer, ifa.s_timer}), 2'b10);
        tick();
        checkOutput("wait_state", int'(state_dbg), 4);
        checkOutput("wait_timer", int'({ifa.en_timer, ifa.s_timer}), 2'b11);

        // Start edge in WAIT is ignored.
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        checkOutput("start_ignored", int'(state_dbg), 4);

        // Moves: right, up, down-over-left, left.
        applyStimulus(4'b0001, 4, 6'b1_01_0_00, 1'b0);
        applyStimulus(4'b1000, 1, 6'b0_00_1_10, 1'b0);
        applyStimulus(4'b0110, 2, 6'b0_00_1_01, 1'b0);
        applyStimulus(4'b0010, 3, 6'b1_10_0_00, 1'b0);

        // Priority with a blocked target: up chosen, no plot, back to TCLR.
        dir_req = 4'b1011;
        tick();
        dir_req = 4'b0000;
        ifa.timer_done = 1'b1;
        ifa.obs_black  = 1'b0;
        tick();
        checkOutput("blk_s_move", int'(ifa.s_move), 1);
        ifa.timer_done = 1'b0;
        tick();
        checkOutput("blk_check_state", int'(state_dbg), 6);
        tick();
        checkOutput("blk_tclr_state", int'(state_dbg), 3);
        tick();
        // Pending was cleared: an empty sample goes straight back to TCLR.
        ifa.timer_done = 1'b1;
        tick();
        checkOutput("empty_sample_state", int'(state_dbg), 5);
        checkOutput("empty_s_move", int'(ifa.s_move), 0);
        ifa.timer_done = 1'b0;
        tick();
        checkOutput("empty_tclr_state", int'(state_dbg), 3);
        tick();

        // Win: hold 100 cycles with no plot, then restart.
        applyStimulus(4'b0001, 4, 6'b1_01_0_00, 1'b1);
        ifa.did_win = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i % 20 == 19) checkOutput("win_hold", int'(game_won), 1);
        end
        checkOutput("win_hold_state", int'(state_dbg), 10);
        pushPlot(2, 1, 0);
        start = 1'b1;
        tick();
        checkOutput("restart_init", int'(state_dbg), 1);
        checkOutput("restart_won", int'(game_won), 0);
        tick();
        tick();
        tick();
        checkOutput("restart_wait", int'(state_dbg), 4);

        // Async reset during ERASE, away from the clock edge.
        dir_req = 4'b0001;
        tick();
        dir_req = 4'b0000;
        ifa.timer_done = 1'b1;
        ifa.obs_black  = 1'b1;
        tick();
        ifa.timer_done = 1'b0;
        tick();
        tick();
        checkOutput("pre_reset_erase", int'(state_dbg), 7);
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("reset_plot_low", int'(ifa.plot), 0);
        checkOutput("reset_state", int'(state_dbg), 0);
        start = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        pushPlot(2, 1, 0);
        start = 1'b1;
        tick();
        checkOutput("rerun_init", int'(state_dbg), 1);
        tick();
        tick();
        tick();
        ifa.timer_done = 1'b1;
        tick();
        checkOutput("rerun_sample", int'(state_dbg), 5);
        checkOutput("rerun_pending_clear", int'(ifa.s_move), 0);
        ifa.timer_done = 1'b0;
        tick();
        checkOutput("rerun_tclr", int'(state_dbg), 3);

        // Frame divide on instance B (FRAMES_PER_STEP=3).
        b_start = 1'b1;
        tick();
        tick();
        tick();
        tick();
        checkOutput("fdiv_wait", int'(b_state), 4);
        b_dir = 4'b0001;
        tick();
        b_dir = 4'b0000;
        ifb.timer_done = 1'b1;
        tick();
        checkOutput("fdiv_tclr1", int'(b_state), 3);
        ifb.timer_done = 1'b0;
        tick();
        ifb.timer_done = 1'b1;
        tick();
        checkOutput("fdiv_tclr2", int'(b_state), 3);
        ifb.timer_done = 1'b0;
        tick();
        ifb.timer_done = 1'b1;
        tick();
        checkOutput("fdiv_sample", int'(b_state), 5);
        checkOutput("fdiv_s_move", int'(ifb.s_move), 4);
        ifb.timer_done = 1'b0;
        tick();
        tick();
        checkOutput("fdiv_blocked_tclr", int'(b_state), 3);

        tick();
        tick();
        checkOutput("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
